sram_like_arbiter: RTL and testbench

Two-master arbiter and sequencer that shares one downstream sram-like port (the AXI bridge) between the instruction-fetch and data-access sram-like ports of the CPU. It grants one master at a time, registers that master's request, drives it to the bridge, waits for completion, and returns read data to the owner only. Data access has priority by default. A starvation counter guarantees that instruction fetch makes forward progress. Exactly one transaction is in flight at any time.

---
 rtl/sram_like_arbiter_if.sv | 50 +++++
 rtl/sram_like_arbiter.sv | 137 +++++++++++++
 tb/tb_sram_like_arbiter.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_like_arbiter_if.sv
// Bundles the instruction, data and downstream sram-like ports shared by the arbiter.
// slave is the arbiter's view; master is the view of the CPU masters plus the bridge.
interface sram_like_arbiter_if;
  logic        inst_req;
  logic        inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr;
  logic [31:0] inst_wdata;
  logic [31:0] inst_rdata;
  logic        inst_addr_ok;
  logic        inst_data_ok;

  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_wstrb;
  logic [31:0] data_rdata;
  logic        data_addr_ok;
  logic        data_data_ok;

  logic        s_req;
  logic        s_wr;
  logic [1:0]  s_size;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic [31:0] s_rdata;
  logic        s_addr_ok;
  logic        s_data_ok;

  modport slave (
    input  inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
    output inst_rdata, inst_addr_ok, inst_data_ok,
    input  data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
    output data_rdata, data_addr_ok, data_data_ok,
    output s_req, s_wr, s_size, s_addr, s_wdata, s_wstrb,
    input  s_rdata, s_addr_ok, s_data_ok
  );

  modport master (
    output inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
    input  inst_rdata, inst_addr_ok, inst_data_ok,
    output data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
    input  data_rdata, data_addr_ok, data_data_ok,
    input  s_req, s_wr, s_size, s_addr, s_wdata, s_wstrb,
    output s_rdata, s_addr_ok, s_data_ok
  );
endinterface

// File: rtl/sram_like_arbiter.sv
// Shares one downstream sram-like port between instruction fetch and data access.
// Data has priority; a starvation counter forces an inst grant after STARVE_LIMIT data wins.
module sram_like_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  sram_like_arbiter_if.slave   bus,
  output logic                 owner,
  output logic                 busy
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  starve_q, starve_d;
  logic        owner_q, owner_d;
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] rdata_q, rdata_d;

  logic gnt_inst;
  logic gnt_data;

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    owner_d  = owner_q;
    wr_d     = wr_q;
    size_d   = size_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    rdata_d  = rdata_q;

    bus.inst_addr_ok = 1'b0;
    bus.data_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b0;
    bus.data_data_ok = 1'b0;
    bus.s_req        = 1'b0;

    gnt_inst = bus.inst_req && (!bus.data_req || (starve_q == LIMIT));
    gnt_data = bus.data_req && !gnt_inst;

    unique case (state_q)
      IDLE: begin
        // addr_ok is suppressed during reset since the capture below is discarded
        if (gnt_inst) begin
          bus.inst_addr_ok = !reset;
          owner_d  = 1'b0;
          wr_d     = bus.inst_wr;
          size_d   = bus.inst_size;
          addr_d   = bus.inst_addr;
          wdata_d  = bus.inst_wdata;
          wstrb_d  = bus.inst_wr ? '1 : '0;
          starve_d = '0;
          state_d  = REQ;
        end else if (gnt_data) begin
          bus.data_addr_ok = !reset;
          owner_d  = 1'b1;
          wr_d     = bus.data_wr;
          size_d   = bus.data_size;
          addr_d   = bus.data_addr;
          wdata_d  = bus.data_wdata;
          wstrb_d  = bus.data_wstrb;
          if (bus.inst_req && (starve_q < LIMIT)) begin
            starve_d = starve_q + 4'd1;
          end
          state_d  = REQ;
        end
      end
      REQ: begin
        bus.s_req = 1'b1;
        if (bus.s_addr_ok) begin
          if (bus.s_data_ok) begin
            rdata_d = bus.s_rdata;
            state_d = RESP;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (bus.s_data_ok) begin
          rdata_d = bus.s_rdata;
          state_d = RESP;
        end
      end
      RESP: begin
        bus.inst_data_ok = !owner_q;
        bus.data_data_ok = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      starve_q <= '0;
      owner_q  <= 1'b0;
      wr_q     <= 1'b0;
      size_q   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      owner_q  <= owner_d;
      wr_q     <= wr_d;
      size_q   <= size_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      rdata_q  <= rdata_d;
    end
  end

  assign bus.s_wr       = wr_q;
  assign bus.s_size     = size_q;
  assign bus.s_addr     = addr_q;
  assign bus.s_wdata    = wdata_q;
  assign bus.s_wstrb    = wstrb_q;
  assign bus.inst_rdata = rdata_q;
  assign bus.data_rdata = rdata_q;
  assign owner          = owner_q;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Bench for sram_like_arbiter: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized masters and bridge.
module tb_sram_like_arbiter;
  localparam int unsigned LIMIT = 4;

  logic clk = 1'b0;
  logic rst;
  logic owner;
  logic busy;

  sram_like_arbiter_if bus ();

  sram_like_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus),
    .owner (owner),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one open transaction at a time, described by lifecycle flags.
  bit          m_open;
  bit          m_sent;
  bit          m_done;
  bit          m_own;
  logic        m_wr;
  logic [1:0]  m_size;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic [31:0] m_rdata;
  int unsigned m_streak;

  function automatic bit m_idle();
    return !(m_open || m_done);
  endfunction

  function automatic bit want_inst();
    return !rst && m_idle() && bus.inst_req && (!bus.data_req || m_streak == LIMIT);
  endfunction

  function automatic bit want_data();
    return !rst && m_idle() && bus.data_req && !want_inst();
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_open <= 0; m_sent <= 0; m_done <= 0; m_own <= 0;
      m_wr <= 0; m_size <= 0; m_addr <= 0; m_wdata <= 0; m_wstrb <= 0; m_rdata <= 0;
      m_streak <= 0;
    end else if (m_done) begin
      m_done <= 0;
    end else if (m_open) begin
      if ((!m_sent && bus.s_addr_ok && bus.s_data_ok) || (m_sent && bus.s_data_ok)) begin
        m_rdata <= bus.s_rdata;
        m_open  <= 0;
        m_sent  <= 0;
        m_done  <= 1;
      end else if (!m_sent && bus.s_addr_ok) begin
        m_sent <= 1;
      end
    end else if (want_inst()) begin
      m_open <= 1; m_own <= 0;
      m_wr <= bus.inst_wr; m_size <= bus.inst_size; m_addr <= bus.inst_addr;
      m_wdata <= bus.inst_wdata; m_wstrb <= bus.inst_wr ? 4'hF : 4'h0;
      m_streak <= 0;
    end else if (want_data()) begin
      m_open <= 1; m_own <= 1;
      m_wr <= bus.data_wr; m_size <= bus.data_size; m_addr <= bus.data_addr;
      m_wdata <= bus.data_wdata; m_wstrb <= bus.data_wstrb;
      if (bus.inst_req && m_streak < LIMIT) m_streak <= m_streak + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("inst_addr_ok", 32'(bus.inst_addr_ok), 32'(want_inst()));
      chk("data_addr_ok", 32'(bus.data_addr_ok), 32'(want_data()));
      chk("s_req", 32'(bus.s_req), 32'(m_open && !m_sent));
      chk("inst_data_ok", 32'(bus.inst_data_ok), 32'(m_done && !m_own));
      chk("data_data_ok", 32'(bus.data_data_ok), 32'(m_done && m_own));
      if (m_done && !m_own) chk("inst_rdata", bus.inst_rdata, m_rdata);
      if (m_done && m_own)  chk("data_rdata", bus.data_rdata, m_rdata);
      chk("s_wr", 32'(bus.s_wr), 32'(m_wr));
      chk("s_size", 32'(bus.s_size), 32'(m_size));
      chk("s_addr", bus.s_addr, m_addr);
      chk("s_wdata", bus.s_wdata, m_wdata);
      chk("s_wstrb", 32'(bus.s_wstrb), 32'(m_wstrb));
      chk("owner", 32'(owner), 32'(m_own));
      chk("busy", 32'(busy), 32'(!m_idle()));
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic quiet();
    bus.inst_req = 0; bus.inst_wr = 0; bus.inst_size = 2'd2; bus.inst_addr = '0; bus.inst_wdata = '0;
    bus.data_req = 0; bus.data_wr = 0; bus.data_size = 2'd2; bus.data_addr = '0; bus.data_wdata = '0;
    bus.data_wstrb = '0;
    bus.s_rdata = '0; bus.s_addr_ok = 0; bus.s_data_ok = 0;
  endtask

  bit seq [10];
  int got;
  int cyc;

  initial begin
    quiet();
    rst = 1;
    tick();
    chk_on = 1;
    samp();
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset owner", 32'(owner), 32'd0);
    chk("reset s_addr", bus.s_addr, 32'd0);
    chk("reset s_req", 32'(bus.s_req), 32'd0);

    // Lone instruction read
    tick(); rst = 0;
    bus.inst_req = 1; bus.inst_addr = 32'hBFC00000;
    samp();
    chk("t1 inst_addr_ok", 32'(bus.inst_addr_ok), 32'd1);
    chk("t1 data_addr_ok", 32'(bus.data_addr_ok), 32'd0);
    tick(); bus.inst_req = 0; bus.s_addr_ok = 1;
    samp();
    chk("t1 s_req", 32'(bus.s_req), 32'd1);
    chk("t1 s_addr", bus.s_addr, 32'hBFC00000);
    chk("t1 s_wstrb", 32'(bus.s_wstrb), 32'd0);
    tick(); bus.s_addr_ok = 0;
    tick(); bus.s_data_ok = 1; bus.s_rdata = 32'h3C1D0000;
    tick(); bus.s_data_ok = 0; bus.s_rdata = '0;
    samp();
    chk("t1 inst_data_ok", 32'(bus.inst_data_ok), 32'd1);
    chk("t1 inst_rdata", bus.inst_rdata, 32'h3C1D0000);
    chk("t1 data_data_ok", 32'(bus.data_data_ok), 32'd0);
    tick();

    // Data write, bridge stalls before accepting
    bus.data_req = 1; bus.data_wr = 1; bus.data_addr = 32'h80001000;
    bus.data_wdata = 32'h12345678; bus.data_wstrb = 4'b0011;
    samp();
    chk("t2 data_addr_ok", 32'(bus.data_addr_ok), 32'd1);
    tick(); bus.data_req = 0; bus.data_wdata = '0; bus.data_wstrb = '0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) bus.s_addr_ok = 1;
      samp();
      chk("t2 s_wr", 32'(bus.s_wr), 32'd1);
      chk("t2 s_wstrb", 32'(bus.s_wstrb), 32'b0011);
      chk("t2 s_wdata", bus.s_wdata, 32'h12345678);
      tick();
    end
    bus.s_addr_ok = 0; bus.s_data_ok = 1;
    tick(); bus.s_data_ok = 0;
    samp();
    chk("t2 data_data_ok pulse", 32'(bus.data_data_ok), 32'd1);
    tick();
    samp();
    chk("t2 data_data_ok drop", 32'(bus.data_data_ok), 32'd0);

    // Same-cycle accept and complete, then a stray completion in IDLE
    bus.inst_req = 1; bus.inst_addr = 32'h00001000;
    tick(); bus.inst_req = 0; bus.s_addr_ok = 1; bus.s_data_ok = 1; bus.s_rdata = 32'hCAFE0001;
    samp();
    chk("t3 s_req", 32'(bus.s_req), 32'd1);
    tick(); bus.s_addr_ok = 0; bus.s_data_ok = 0; bus.s_rdata = '0;
    samp();
    chk("t3 inst_data_ok", 32'(bus.inst_data_ok), 32'd1);
    chk("t3 inst_rdata", bus.inst_rdata, 32'hCAFE0001);
    tick(); bus.s_data_ok = 1;
    tick(); bus.s_data_ok = 0;
    samp();
    chk("t3 stray inst_data_ok", 32'(bus.inst_data_ok), 32'd0);
    chk("t3 stray data_data_ok", 32'(bus.data_data_ok), 32'd0);
    chk("t3 stray busy", 32'(busy), 32'd0);

    // Simultaneous requests: data first, inst on the next IDLE
    tick();
    bus.inst_req = 1; bus.data_req = 1; bus.data_wr = 0; bus.inst_addr = 32'h2000;
    samp();
    chk("t4 data_addr_ok", 32'(bus.data_addr_ok), 32'd1);
    chk("t4 inst_addr_ok", 32'(bus.inst_addr_ok), 32'd0);
    tick(); bus.data_req = 0; bus.s_addr_ok = 1; bus.s_data_ok = 1;
    samp();
    chk("t4 owner", 32'(owner), 32'd1);
    tick(); bus.s_addr_ok = 0; bus.s_data_ok = 0;
    tick();
    samp();
    chk("t4 inst next", 32'(bus.inst_addr_ok), 32'd1);
    tick(); bus.inst_req = 0; bus.s_addr_ok = 1; bus.s_data_ok = 1;
    tick(); bus.s_addr_ok = 0; bus.s_data_ok = 0;
    tick();

    // Reset during WAIT after building a starvation streak
    bus.inst_req = 1; bus.data_req = 1;
    tick(); bus.s_addr_ok = 1; bus.s_data_ok = 1;
    tick(); bus.s_addr_ok = 0; bus.s_data_ok = 0;
    tick(); bus.s_addr_ok = 0;
    tick(); bus.s_addr_ok = 1;
    tick(); bus.s_addr_ok = 0; bus.inst_req = 0; bus.data_req = 0; rst = 1;
    samp();
    chk("t5 busy in WAIT", 32'(busy), 32'd1);
    tick(); rst = 0; bus.s_data_ok = 1; bus.s_rdata = 32'hDEADBEEF;
    samp();
    chk("t5 busy", 32'(busy), 32'd0);
    chk("t5 owner", 32'(owner), 32'd0);
    chk("t5 s_req", 32'(bus.s_req), 32'd0);
    chk("t5 s_addr", bus.s_addr, 32'd0);
    chk("t5 s_wstrb", 32'(bus.s_wstrb), 32'd0);
    tick(); bus.s_data_ok = 0; bus.s_rdata = '0;
    samp();
    chk("t5 late data_data_ok", 32'(bus.data_data_ok), 32'd0);
    chk("t5 late inst_data_ok", 32'(bus.inst_data_ok), 32'd0);
    chk("t5 late rdata", bus.data_rdata, 32'd0);

    // Starvation: both held high, counter restarted by reset
    tick();
    bus.inst_req = 1; bus.data_req = 1;
    got = 0; cyc = 0;
    while (got < 10 && cyc < 200) begin
      samp();
      if (bus.data_addr_ok) begin seq[got] = 1; got++; end
      else if (bus.inst_addr_ok) begin seq[got] = 0; got++; end
      tick(); cyc++;
      bus.s_addr_ok = bus.s_req; bus.s_data_ok = bus.s_req;
    end
    if (got < 10) chk("t6 grant count", 32'(got), 32'd10);
    for (int i = 0; i < got; i++) begin
      chk($sformatf("t6 grant %0d is data", i), 32'(seq[i]), (i % 5 == 4) ? 32'd0 : 32'd1);
    end
    bus.inst_req = 0; bus.data_req = 0;
    for (int i = 0; i < 4; i++) begin
      tick(); bus.s_addr_ok = bus.s_req; bus.s_data_ok = bus.s_req;
    end

    // Randomized masters and bridge, including stray handshakes and resets
    for (int unsigned n = 0; n < 4000; n++) begin
      tick();
      rst = ($urandom % 250 == 0);
      bus.inst_req   = ($urandom % 3 != 0);
      bus.inst_wr    = ($urandom % 4 == 0);
      bus.inst_size  = 2'($urandom % 3);
      bus.inst_addr  = $urandom;
      bus.inst_wdata = $urandom;
      bus.data_req   = ($urandom % 3 != 0);
      bus.data_wr    = $urandom % 2 == 1;
      bus.data_size  = 2'($urandom % 3);
      bus.data_addr  = $urandom;
      bus.data_wdata = $urandom;
      bus.data_wstrb = 4'($urandom);
      bus.s_rdata    = $urandom;
      if (bus.s_req) begin
        bus.s_addr_ok = ($urandom % 2 == 1);
        bus.s_data_ok = bus.s_addr_ok && ($urandom % 3 == 0);
      end else begin
        bus.s_addr_ok = ($urandom % 5 == 0);
        bus.s_data_ok = ($urandom % 3 == 0);
      end
    end
    tick(); rst = 0; quiet();
    tick();
    samp();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
